vga_scan_controller: RTL and testbench

Raster scan generator driving every sprite renderer on the board display. Produces the `DrawX`/`DrawY` pixel coordinates consumed by the piece and board sprite modules, plus VGA sync and blanking. Sprite modules return colour one `vga_clk` after the coordinates are presented, because their ROM has one cycle of latency. This block therefore delays sync and blanking by a matching, parameterised number of pixel cycles, so colour and sync reach the DAC aligned.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/sync_delay.sv | 34 +++
 rtl/vga_scan_controller.sv | 100 ++++++++++
 tb/tb_vga_scan_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the scan controller
// and every sprite module that consumes DrawX/DrawY.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int MAX_PIPE_DELAY = 4;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic display_on;
  } sync_bundle_t;

  // Idle state of the sync bundle: syncs inactive (high), blanked.
  localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, display_on: 1'b0};

  function automatic int line_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register of configurable depth; every stage resets to RESET_VAL.
// DEPTH = 0 degenerates to a straight wire.
module sync_delay #(
  parameter int                WIDTH     = 3,
  parameter int                DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// Raster scan generator: registered DrawX/DrawY counters, sync/blank decode
// delayed by PIPE_DELAY pixel steps to line up with sprite ROM latency.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t       x_cnt;
  coord_t       y_cnt;
  sync_bundle_t raw_sync;
  sync_bundle_t dly_sync;

  // Pulses only last one clock, even if pix_en drops on the next cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (x_cnt == H_LAST) begin
          x_cnt      <= '0;
          line_start <= 1'b1;
          if (y_cnt == V_LAST) begin
            y_cnt       <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            y_cnt <= y_cnt + 10'd1;
          end
        end else begin
          x_cnt <= x_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    raw_sync            = SYNC_IDLE;
    raw_sync.hs         = !((x_cnt >= HS_START) && (x_cnt < HS_END));
    raw_sync.vs         = !((y_cnt >= VS_START) && (y_cnt < VS_END));
    raw_sync.display_on = (x_cnt < H_VIS_END) && (y_cnt < V_VIS_END);
  end

  sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (pix_en),
    .din     (raw_sync),
    .dout    (dly_sync)
  );

  assign DrawX      = x_cnt;
  assign DrawY      = y_cnt;
  assign hs         = dly_sync.hs;
  assign vs         = dly_sync.vs;
  assign display_on = dly_sync.display_on;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a default-timing instance plus three reduced-timing
// instances (delay 1, 0, 3) checked against a behavioural model through a scoreboard queue.
module tb_vga_scan_controller;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic pix_en  = 1'b0;

  always #5 vga_clk = ~vga_clk;

  logic [9:0] x_s, y_s, x_0, y_0, x_3, y_3, x_d, y_d;
  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic       hs_0, vs_0, de_0, ls_0, fs_0;
  logic       hs_3, vs_3, de_3, ls_3, fs_3;
  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [7:0] fc_s, fc_0, fc_3, fc_d;

  vga_scan_controller dut_def (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(x_d), .DrawY(y_d), .hs(hs_d), .vs(vs_d), .display_on(de_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d));

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(1)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(x_s), .DrawY(y_s), .hs(hs_s), .vs(vs_s), .display_on(de_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s));

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(0)
  ) dut_d0 (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(x_0), .DrawY(y_0), .hs(hs_0), .vs(vs_0), .display_on(de_0),
    .line_start(ls_0), .frame_start(fs_0), .frame_count(fc_0));

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(3)
  ) dut_d3 (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(x_3), .DrawY(y_3), .hs(hs_3), .vs(vs_3), .display_on(de_3),
    .line_start(ls_3), .frame_start(fs_3), .frame_count(fc_3));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] d1;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic [2:0] d0;
    logic [2:0] d3;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model of the reduced-timing instances
  int         mx = 0, my = 0;
  logic [7:0] mfc = '0;
  logic       mls = 1'b0, mfs = 1'b0;
  logic [2:0] hist [1:4];

  function automatic logic [2:0] raw_s(input int x, input int y);
    logic h, v, d;
    h = !((x >= HV + HF) && (x < HV + HF + HS));
    v = !((y >= VV + VF) && (y < VV + VF + VS));
    d = (x < HV) && (y < VV);
    return {h, v, d};
  endfunction

  task automatic step(input logic rst, input logic en);
    exp_t e;
    reset  = rst;
    pix_en = en;
    if (rst) begin
      mx = 0; my = 0; mfc = '0; mls = 1'b0; mfs = 1'b0;
      for (int k = 1; k <= 4; k++) hist[k] = 3'b110;
    end else if (en) begin
      for (int k = 4; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = raw_s(mx, my);
      mls = (mx == HT - 1);
      mfs = mls && (my == VT - 1);
      if (mls) begin
        mx = 0;
        if (mfs) begin
          my = 0;
          mfc = mfc + 8'd1;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end else begin
      mls = 1'b0;
      mfs = 1'b0;
    end
    e.x  = 10'(mx);
    e.y  = 10'(my);
    e.d1 = hist[1];
    e.ls = mls;
    e.fs = mfs;
    e.fc = mfc;
    e.d0 = raw_s(mx, my);
    e.d3 = hist[3];
    sb_q.push_back(e);
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  always @(negedge vga_clk) begin
    exp_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {x_s, y_s, hs_s, vs_s, de_s, ls_s, fs_s, fc_s, hs_0, vs_0, de_0, hs_3, vs_3, de_3};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, a, e);
      end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    vectors++;
    if ({x_s, y_s, fc_s} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_counts actual=%h expected=0", {x_s, y_s, fc_s});
    end
    vectors++;
    if ({hs_s, vs_s, de_s, ls_s, fs_s} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_sync actual=%b expected=11000", {hs_s, vs_s, de_s, ls_s, fs_s});
    end
    vectors++;
    if ({x_d, y_d, fc_d, hs_d, vs_d, de_d, ls_d, fs_d} !== {28'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL reset_default actual=%h expected=%h",
               {x_d, y_d, fc_d, hs_d, vs_d, de_d, ls_d, fs_d}, {28'd0, 5'b11000});
    end
  endtask

  task automatic test_first_line();
    int first_low = -1;
    for (int i = 1; i <= 800; i++) begin
      step(1'b0, 1'b1);
      vectors++;
      if (x_d !== 10'(i % 800) || y_d !== 10'(i == 800) || ls_d !== (i == 800)) begin
        miscompares++;
        $display("FAIL first_line step=%0d actual x=%0d y=%0d ls=%b expected x=%0d y=%0d ls=%b",
                 i, x_d, y_d, ls_d, i % 800, (i == 800), (i == 800));
      end
      if (hs_d === 1'b0 && first_low < 0) first_low = int'(x_d);
    end
    vectors++;
    if (first_low != 657) begin
      miscompares++;
      $display("FAIL default_hs_first_low actual=%0d expected=657", first_low);
    end
  endtask

  task automatic test_full_frame();
    int hs_low = 0, vs_low = 0, de_high = 0;
    int f1 = -1, f0 = -1, f3 = -1;
    step(1'b1, 1'b0);
    for (int i = 1; i <= HT * VT; i++) begin
      step(1'b0, 1'b1);
      if (hs_s === 1'b0) hs_low++;
      if (vs_s === 1'b0) vs_low++;
      if (de_s === 1'b1) de_high++;
      if (hs_s === 1'b0 && f1 < 0) f1 = int'(x_s);
      if (hs_0 === 1'b0 && f0 < 0) f0 = int'(x_0);
      if (hs_3 === 1'b0 && f3 < 0) f3 = int'(x_3);
    end
    vectors++;
    if (hs_low != HS * VT) begin
      miscompares++;
      $display("FAIL hs_low_count actual=%0d expected=%0d", hs_low, HS * VT);
    end
    vectors++;
    if (vs_low != VS * HT) begin
      miscompares++;
      $display("FAIL vs_low_count actual=%0d expected=%0d", vs_low, VS * HT);
    end
    vectors++;
    if (de_high != HV * VV) begin
      miscompares++;
      $display("FAIL display_on_count actual=%0d expected=%0d", de_high, HV * VV);
    end
    vectors++;
    if (fs_s !== 1'b1 || fc_s !== 8'd1) begin
      miscompares++;
      $display("FAIL frame_end actual fs=%b fc=%0d expected fs=1 fc=1", fs_s, fc_s);
    end
    vectors++;
    if (f1 != HV + HF + 1 || f0 != HV + HF || f3 != HV + HF + 3) begin
      miscompares++;
      $display("FAIL pipe_delay_hs_edge actual d1=%0d d0=%0d d3=%0d expected %0d %0d %0d",
               f1, f0, f3, HV + HF + 1, HV + HF, HV + HF + 3);
    end
  endtask

  task automatic test_toggle_enable();
    logic [9:0] px;
    logic       phs, pls;
    int         ls_seen = 0;
    step(1'b1, 1'b0);
    px = x_s; phs = hs_s; pls = ls_s;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (i % 2) == 0);
      vectors++;
      if ((i % 2) == 0) begin
        if (x_s !== 10'((int'(px) + 1) % HT)) begin
          miscompares++;
          $display("FAIL toggle_advance i=%0d actual=%0d expected=%0d", i, x_s, (int'(px) + 1) % HT);
        end
      end else if (x_s !== px || hs_s !== phs) begin
        miscompares++;
        $display("FAIL toggle_hold i=%0d actual x=%0d hs=%b expected x=%0d hs=%b", i, x_s, hs_s, px, phs);
      end
      vectors++;
      if (ls_s === 1'b1 && pls === 1'b1) begin
        miscompares++;
        $display("FAIL line_start_width i=%0d actual=2 expected=1", i);
      end
      if (ls_s === 1'b1) ls_seen++;
      px = x_s; phs = hs_s; pls = ls_s;
    end
    vectors++;
    if (ls_seen != 1) begin
      miscompares++;
      $display("FAIL toggle_line_starts actual=%0d expected=1", ls_seen);
    end
  endtask

  task automatic test_frame_wrap();
    int fs_count = 0;
    step(1'b1, 1'b0);
    for (int f = 0; f < 256; f++) begin
      for (int s = 0; s < HT * VT; s++) begin
        step(1'b0, 1'b1);
        if (fs_s === 1'b1) fs_count++;
      end
      if (f == 254) begin
        vectors++;
        if (fc_s !== 8'd255) begin
          miscompares++;
          $display("FAIL frame_count_255 actual=%0d expected=255", fc_s);
        end
      end
    end
    vectors++;
    if (fs_count != 256 || fc_s !== 8'd0) begin
      miscompares++;
      $display("FAIL frame_wrap actual pulses=%0d fc=%0d expected pulses=256 fc=0", fs_count, fc_s);
    end
  endtask

  task automatic test_mid_frame_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < HT * VT + 4 * HT + 5; i++) step(1'b0, 1'b1);
    vectors++;
    if (x_s !== 10'd5 || y_s !== 10'd4 || fc_s !== 8'd1) begin
      miscompares++;
      $display("FAIL pre_reset_position actual x=%0d y=%0d fc=%0d expected 5 4 1", x_s, y_s, fc_s);
    end
    step(1'b1, 1'b1);
    vectors++;
    if ({x_s, y_s, fc_s, hs_s, vs_s, de_s, ls_s, fs_s} !== {28'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL mid_reset_outputs actual=%h expected=%h",
               {x_s, y_s, fc_s, hs_s, vs_s, de_s, ls_s, fs_s}, {28'd0, 5'b11000});
    end
    step(1'b0, 1'b1);
    vectors++;
    if (x_s !== 10'd1 || fc_s !== 8'd0 || fs_s !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_restart actual x=%0d fc=%0d fs=%b expected x=1 fc=0 fs=0", x_s, fc_s, fs_s);
    end
  endtask

  initial begin
    for (int k = 1; k <= 4; k++) hist[k] = 3'b110;
    test_reset();
    test_first_line();
    test_full_frame();
    test_toggle_enable();
    test_frame_wrap();
    test_mid_frame_reset();
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
